calc_display_mux: RTL and testbench

- Downstream display stage for the calculator core.
- Consumes the core's serialized digit stream (status/data/pos) and assembles it into a double-buffered 8-digit frame.
- Drives a time-multiplexed 8-digit common-anode seven-segment display with leading-zero blanking, plus an error banner and status LEDs.

---
 rtl/calc_disp_pkg.sv | 27 ++
 rtl/calc_display_mux_seg7_decoder.sv | 19 +
 rtl/calc_display_mux.sv | 126 ++++++++++++
 tb/tb_calc_display_mux.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/calc_disp_pkg.sv
// rtl/calc_disp_pkg.sv - shared constants, display codes and segment table for calc_display_mux
//
// Purpose: core status encodings, digit count, display code enum and the
// active-low {g,f,e,d,c,b,a} segment patterns indexed by display code.
package calc_disp_pkg;

  // Core status encodings
  localparam logic [1:0] ST_ERRO   = 2'b00;
  localparam logic [1:0] ST_BUSY   = 2'b01;
  localparam logic [1:0] ST_PRONTO = 2'b10;
  localparam logic [1:0] ST_PRINT  = 2'b11;

  localparam int NUM_DIG = 8;

  typedef enum logic [3:0] {
    D0, D1, D2, D3, D4, D5, D6, D7, D8, D9,
    C_E, C_R, C_O, C_BLANK
  } disp_code_e;

  // Entry n is the pattern for display code n (D0 is the rightmost element).
  localparam logic [13:0][6:0] SEG_TABLE = {
    7'h7F, 7'h23, 7'h2F, 7'h06,
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/calc_display_mux_seg7_decoder.sv
// rtl/calc_display_mux_seg7_decoder.sv - combinational display code to seven-segment pattern
//
// Ports:
//   code : display code (digit, E/r/o or blank)
//   seg  : active-low segments {g,f,e,d,c,b,a}
module seg7_decoder
  import calc_disp_pkg::*;
(
  input  disp_code_e  code,
  output logic [6:0]  seg
);

  // Codes beyond C_BLANK are not produced by the top; treat them as blank.
  always_comb begin
    seg = SEG_TABLE[C_BLANK];
    if (code <= C_BLANK) seg = SEG_TABLE[code];
  end

endmodule

// File: rtl/calc_display_mux.sv
// rtl/calc_display_mux.sv - double-buffered 8-digit frame capture and multiplexed 7-seg display driver
//
// Ports:
//   clock, reset   : system clock; asynchronous active-high reset
//   status[1:0]    : core status (00 erro, 01 ocupado, 10 pronto, 11 imprimindo)
//   data[3:0]      : digit value from the core (10-15 shown blank)
//   pos[3:0]       : core print counter; digit pos-1 is presented while pos is 1..8
//   an[7:0]        : active-low one-hot digit enables, an[0] = units digit
//   seg[6:0]       : active-low segments {g,f,e,d,c,b,a}
//   dp             : decimal point, always off
//   err_led        : sticky error flag
//   busy_led       : registered status==ocupado
//   frame_done     : one-cycle pulse after a frame is committed to the active buffer
module calc_display_mux
  import calc_disp_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] status,
  input  logic [3:0] data,
  input  logic [3:0] pos,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       err_led,
  output logic       busy_led,
  output logic       frame_done
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [3:0]         shadow [NUM_DIG];
  logic [3:0]         active [NUM_DIG];
  logic [PW-1:0]      presc;
  logic [2:0]         scan_idx;
  logic               err;

  logic               capture_en;
  logic               commit;
  logic [3:0]         pos_m1;
  logic [NUM_DIG-1:0] keep;
  logic               seen_nz;
  logic [3:0]         cur;
  disp_code_e         code;
  logic [6:0]         seg_next;

  assign capture_en = (status == ST_PRINT) && (pos != 4'd0) && (pos <= 4'd8);
  assign commit     = (status == ST_PRINT) && (pos == 4'd8);
  assign pos_m1     = pos - 4'd1;

  // keep[i]: some digit at or above i is non-zero, so digit i is not a leading zero.
  always_comb begin
    keep    = '0;
    seen_nz = 1'b0;
    for (int i = NUM_DIG - 1; i >= 0; i--) begin
      seen_nz = seen_nz | (active[i] != 4'd0);
      keep[i] = seen_nz;
    end
    keep[0] = 1'b1;
  end

  // Content of the digit being scanned, from the pre-update active buffer.
  always_comb begin
    cur  = active[scan_idx];
    code = C_BLANK;
    if (err) begin
      case (scan_idx)
        3'd3:       code = C_E;
        3'd2, 3'd1: code = C_R;
        3'd0:       code = C_O;
        default:    code = C_BLANK;
      endcase
    end else if (keep[scan_idx] && (cur <= 4'd9)) begin
      code = disp_code_e'(cur);
    end
  end

  seg7_decoder u_dec (
    .code (code),
    .seg  (seg_next)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIG; i++) begin
        shadow[i] <= 4'd0;
        active[i] <= 4'd0;
      end
      presc      <= '0;
      scan_idx   <= 3'd0;
      err        <= 1'b0;
      an         <= 8'hFF;
      seg        <= 7'h7F;
      busy_led   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (capture_en) shadow[pos_m1[2:0]] <= data;

      // Digit 7 arrives on the commit edge itself, so take it straight from data.
      if (commit) begin
        for (int i = 0; i < NUM_DIG - 1; i++) active[i] <= shadow[i];
        active[NUM_DIG-1] <= data;
      end
      frame_done <= commit;

      if (status == ST_ERRO) err <= 1'b1;
      busy_led <= (status == ST_BUSY);

      if (presc == PW'(SCAN_DIV - 1)) begin
        presc    <= '0;
        scan_idx <= scan_idx + 3'd1;
      end else begin
        presc <= presc + 1'b1;
      end

      an  <= ~(8'd1 << scan_idx);
      seg <= seg_next;
    end
  end

  assign dp      = 1'b1;
  assign err_led = err;

endmodule

// File: tb/tb_calc_display_mux.sv
// tb/tb_calc_display_mux.sv - scoreboard testbench for calc_display_mux
module tb_calc_display_mux;

  localparam logic [1:0] S_ERRO = 2'b00, S_BUSY = 2'b01, S_PRONTO = 2'b10, S_PRINT = 2'b11;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] status = S_PRONTO;
  logic [3:0] data = 4'd0;
  logic [3:0] pos = 4'd0;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       err_led;
  logic       busy_led;
  logic       frame_done;

  calc_display_mux #(.SCAN_DIV(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .status     (status),
    .data       (data),
    .pos        (pos),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .err_led    (err_led),
    .busy_led   (busy_led),
    .frame_done (frame_done)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0][6:0] seg;
    logic            err;
    logic            busy;
  } exp_t;

  exp_t exp_q [$];
  int   checks = 0;
  int   failures = 0;
  int   fd_pulses = 0;
  int   fd_high = 0;
  logic fd_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, want);
    end
  endtask

  always @(negedge clock) begin
    if (frame_done) fd_high++;
    if (frame_done && !fd_prev) fd_pulses++;
    fd_prev = frame_done;
  end

  // Monitor: for each expected display, observe one lit slot of every digit and compare.
  initial begin : monitor
    exp_t       cur;
    logic [7:0] seen;
    logic [6:0] got [8];
    int         idx;
    forever begin
      @(negedge clock);
      if (exp_q.size() != 0) begin
        cur  = exp_q[0];
        seen = 8'h00;
        for (int c = 0; c < 100 && seen != 8'hFF; c++) begin
          @(negedge clock);
          if (an != 8'hFF) begin
            chk("an_onehot", $countones(an), 7);
            idx = 0;
            for (int i = 0; i < 8; i++) if (!an[i]) idx = i;
            got[idx]  = seg;
            seen[idx] = 1'b1;
          end
        end
        chk("scan_cover", seen, 8'hFF);
        for (int i = 0; i < 8; i++) chk($sformatf("seg_digit%0d", i), got[i], cur.seg[i]);
        chk("err_led", err_led, cur.err);
        chk("busy_led", busy_led, cur.busy);
        chk("dp", dp, 1'b1);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic drive(input logic [1:0] s, input logic [3:0] p, input logic [3:0] d);
    status = s; pos = p; data = d;
    @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0][3:0] digs);
    for (int p = 1; p <= 8; p++) drive(S_PRINT, 4'(p), digs[p-1]);
    drive(S_PRONTO, 4'd0, 4'd0);
  endtask

  task automatic expect_disp(input logic [7:0][6:0] s, input logic e, input logic b);
    exp_t x;
    x.seg = s; x.err = e; x.busy = b;
    exp_q.push_back(x);
    for (int c = 0; c < 300 && exp_q.size() != 0; c++) @(negedge clock);
    if (exp_q.size() != 0) chk("monitor_drain", exp_q.size(), 0);
  endtask

  task automatic chk_frames(input string name, input int p0, input int h0, input int want);
    repeat (3) @(negedge clock);
    chk({name, "_fd_pulses"}, fd_pulses - p0, want);
    chk({name, "_fd_cycles"}, fd_high - h0, want);
  endtask

  localparam logic [7:0][6:0] DISP_ZERO = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};
  localparam logic [7:0][6:0] DISP_123  = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30};
  localparam logic [7:0][6:0] DISP_FULL = {7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24};
  localparam logic [7:0][6:0] DISP_ERR  = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h06, 7'h2F, 7'h2F, 7'h23};

  initial begin : stim
    int p0, h0;
    logic [7:0] exp_an;

    // 1. reset values, first edge and scan sequence
    repeat (3) @(negedge clock);
    chk("rst_an", an, 8'hFF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1'b1);
    chk("rst_err", err_led, 1'b0);
    chk("rst_busy", busy_led, 1'b0);
    chk("rst_fd", frame_done, 1'b0);
    reset = 1'b0;
    for (int k = 0; k < 36; k++) begin
      @(posedge clock); #1;
      exp_an = ~(8'd1 << ((k / 4) % 8));
      chk($sformatf("scan_an_%0d", k), an, exp_an);
      if (k == 0) chk("first_seg", seg, 7'h40);
    end
    @(negedge clock);
    expect_disp(DISP_ZERO, 1'b0, 1'b0);

    // 2. frame "123"
    p0 = fd_pulses; h0 = fd_high;
    send_frame({4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3});
    chk_frames("f123", p0, h0, 1);
    expect_disp(DISP_123, 1'b0, 1'b0);

    // 3. full frame "98765432"
    p0 = fd_pulses; h0 = fd_high;
    send_frame({4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2});
    chk_frames("full", p0, h0, 1);
    expect_disp(DISP_FULL, 1'b0, 1'b0);

    // 4. "123" then an aborted frame of 9s
    send_frame({4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3});
    p0 = fd_pulses; h0 = fd_high;
    for (int p = 1; p <= 4; p++) drive(S_PRINT, 4'(p), 4'd9);
    drive(S_PRONTO, 4'd5, 4'd9);
    drive(S_PRONTO, 4'd0, 4'd0);
    chk_frames("abort", p0, h0, 0);
    expect_disp(DISP_123, 1'b0, 1'b0);

    // busy indicator follows status one edge later
    drive(S_BUSY, 4'd0, 4'd0);
    chk("busy_on", busy_led, 1'b1);
    drive(S_PRONTO, 4'd0, 4'd0);
    chk("busy_off", busy_led, 1'b0);

    // 5. one error cycle, then frame "45": banner persists, commit still occurs
    drive(S_ERRO, 4'd0, 4'd0);
    drive(S_PRONTO, 4'd0, 4'd0);
    chk("err_set", err_led, 1'b1);
    p0 = fd_pulses; h0 = fd_high;
    send_frame({4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd4, 4'd5});
    chk_frames("err45", p0, h0, 1);
    expect_disp(DISP_ERR, 1'b1, 1'b0);

    // 6. async reset mid-frame at pos=4
    for (int p = 1; p <= 3; p++) drive(S_PRINT, 4'(p), 4'd7);
    status = S_PRINT; pos = 4'd4; data = 4'd7;
    #2 reset = 1'b1;
    #1;
    chk("async_an", an, 8'hFF);
    chk("async_seg", seg, 7'h7F);
    chk("async_err", err_led, 1'b0);
    chk("async_fd", frame_done, 1'b0);
    @(negedge clock);
    status = S_PRONTO; pos = 4'd0; data = 4'd0;
    @(negedge clock);
    reset = 1'b0;
    p0 = fd_pulses; h0 = fd_high;
    repeat (20) @(negedge clock);
    chk("post_rst_fd_pulses", fd_pulses - p0, 0);
    chk("post_rst_fd_cycles", fd_high - h0, 0);
    expect_disp(DISP_ZERO, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
